// File: rtl/fwd_engine_sequencer_if.sv
// Handshake and control bundle between the host/engine side and the
// FWD_ENGINE iteration sequencer.
interface fwd_engine_sequencer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int ITER_WIDTH = 5
);
  logic                  start;
  logic                  abort;
  logic                  err_ok;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  layer_sel;
  logic                  acc_en;
  logic                  acc_clr;
  logic                  l1_capture;
  logic                  l2_capture;
  logic [ITER_WIDTH-1:0] iter_cnt;
  logic                  busy;
  logic                  done;
  logic                  converged;

  // Host/engine side: issues commands and reports the error flag.
  modport master (
    output start, abort, err_ok,
    input  in_addr, layer_sel, acc_en, acc_clr, l1_capture, l2_capture,
           iter_cnt, busy, done, converged
  );

  // Sequencer side.
  modport slave (
    input  start, abort, err_ok,
    output in_addr, layer_sel, acc_en, acc_clr, l1_capture, l2_capture,
           iter_cnt, busy, done, converged
  );
endinterface

// File: rtl/fwd_engine_sequencer.sv
// Iteration controller for FWD_ENGINE: per iteration, an L1 MACC pass
// (feed + drain) followed by an L2 pass, then a convergence check.
// Outputs are registered from the current state, so every output appears
// one cycle after the state that produces it.
module fwd_engine_sequencer #(
  parameter int NUM_UNKNOWNS = 2,
  parameter int NUM_NONLIN   = 1,
  parameter int MACC_LATENCY = 4,
  parameter int MAX_ITER     = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int ITER_WIDTH   = 5
) (
  input logic                    clk,
  input logic                    rst,
  fwd_engine_sequencer_if.slave  bus
);

  localparam int L1_LEN = NUM_UNKNOWNS + 1;
  localparam int L2_LEN = NUM_UNKNOWNS + NUM_NONLIN + 1;
  localparam int LAT_W  = $clog2(MACC_LATENCY);
  localparam int CNT_W  = (ADDR_WIDTH > LAT_W) ? ADDR_WIDTH : LAT_W;

  localparam logic [CNT_W-1:0]      L1_LAST   = CNT_W'(L1_LEN - 1);
  localparam logic [CNT_W-1:0]      L2_LAST   = CNT_W'(L2_LEN - 1);
  localparam logic [CNT_W-1:0]      LAT_LAST  = CNT_W'(MACC_LATENCY - 1);
  localparam logic [ITER_WIDTH-1:0] ITER_LAST = ITER_WIDTH'(MAX_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_FEED, S_L1_DRAIN, S_L2_FEED, S_L2_DRAIN, S_CHECK, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;       // operand index in feed, cycle index in drain
  logic [ITER_WIDTH-1:0] iter_q, iter_d;
  logic                  conv_q, conv_d;

  logic abort_hit, run, in_feed, in_l2, drain_last;

  // Decode of the current state shared by next-state and output logic.
  assign abort_hit  = bus.abort && (state_q != S_IDLE);
  assign run        = (state_q != S_IDLE) && !bus.abort;
  assign in_feed    = (state_q == S_L1_FEED) || (state_q == S_L2_FEED);
  assign in_l2      = (state_q == S_L2_FEED) || (state_q == S_L2_DRAIN);
  assign drain_last = (cnt_q == LAT_LAST);

  // State and counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      conv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      conv_q  <= conv_d;
    end
  end

  // Next-state logic; counters only advance below their terminal value.
  always_comb begin
    // NOTE: every signal gets a hold default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    conv_d  = conv_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_L1_FEED;
          cnt_d   = '0;
          iter_d  = '0;
          conv_d  = 1'b0;
        end
      end
      S_L1_FEED: begin
        if (cnt_q == L1_LAST) begin
          state_d = S_L1_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_L1_DRAIN: begin
        if (drain_last) begin
          state_d = S_L2_FEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_L2_FEED: begin
        if (cnt_q == L2_LAST) begin
          state_d = S_L2_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_L2_DRAIN: begin
        if (drain_last) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHECK: begin
        if (bus.err_ok) begin
          state_d = S_DONE;
          conv_d  = 1'b1;
        end else if (iter_q == ITER_LAST) begin
          state_d = S_DONE;
          conv_d  = 1'b0;
        end else begin
          state_d = S_L1_FEED;
          iter_d  = iter_q + ITER_WIDTH'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition, including the iteration increment.
    if (abort_hit) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      iter_d  = iter_q;
      conv_d  = 1'b0;
    end
  end

  // Registered outputs; an abort blanks them on the very edge it is sampled.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: reset clears only control registers; this block holds no storage arrays.
    if (rst) begin
      bus.in_addr    <= '0;
      bus.layer_sel  <= 1'b0;
      bus.acc_en     <= 1'b0;
      bus.acc_clr    <= 1'b0;
      bus.l1_capture <= 1'b0;
      bus.l2_capture <= 1'b0;
      bus.iter_cnt   <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.converged  <= 1'b0;
    end else begin
      bus.in_addr    <= (run && in_feed) ? cnt_q[ADDR_WIDTH-1:0] : '0;
      bus.layer_sel  <= run && in_l2;
      bus.acc_en     <= run && in_feed;
      bus.acc_clr    <= run && in_feed && (cnt_q == '0);
      bus.l1_capture <= run && (state_q == S_L1_DRAIN) && drain_last;
      bus.l2_capture <= run && (state_q == S_L2_DRAIN) && drain_last;
      bus.iter_cnt   <= iter_q;
      bus.busy       <= run;
      bus.done       <= run && (state_q == S_DONE);
      bus.converged  <= conv_q && !abort_hit;
    end
  end

endmodule

// File: tb/tb_fwd_engine_sequencer.sv
// Bench for fwd_engine_sequencer: a cycle-offset model predicts every output
// each cycle, and directed scenarios pin key timings with literal values.
module tb_fwd_engine_sequencer;

  localparam int L1_LEN   = 3;
  localparam int L2_LEN   = 4;
  localparam int LAT      = 4;
  localparam int MAX_ITER = 16;
  localparam int IT_LEN   = L1_LEN + L2_LEN + 2 * LAT + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fwd_engine_sequencer_if #(.ADDR_WIDTH(4), .ITER_WIDTH(5)) bus ();

  fwd_engine_sequencer #(
    .NUM_UNKNOWNS(2), .NUM_NONLIN(1), .MACC_LATENCY(LAT),
    .MAX_ITER(MAX_ITER), .ADDR_WIDTH(4), .ITER_WIDTH(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] dut_vec();
    return {bus.in_addr, bus.layer_sel, bus.acc_en, bus.acc_clr, bus.l1_capture,
            bus.l2_capture, bus.iter_cnt, bus.busy, bus.done, bus.converged};
  endfunction

  // ---------------- behavioural model ----------------
  // m_t counts edges since the edge that accepted START; output window t
  // shows offset p = (t-1) mod IT_LEN of iteration (t-1) / IT_LEN.
  bit       m_active = 0, m_finish = 0, m_conv = 0;
  int       m_t = 0;
  bit [3:0] e_addr = 0;
  bit [4:0] e_iter = 0;
  bit       e_layer = 0, e_en = 0, e_clr = 0, e_c1 = 0, e_c2 = 0;
  bit       e_busy = 0, e_done = 0, e_conv = 0;

  always @(posedge clk) begin
    int i, p;
    {e_addr, e_layer, e_en, e_clr, e_c1, e_c2, e_busy, e_done} = '0;
    if (rst) begin
      m_active = 0; m_finish = 0; e_iter = 0; e_conv = 0;
    end else if (!m_active) begin
      if (bus.start && !bus.abort) begin
        m_active = 1; m_t = 0; m_finish = 0;
      end
    end else begin
      m_t++;
      if (!m_finish) e_iter = 5'((m_t - 1) / IT_LEN);
      if (bus.abort) begin
        m_active = 0; e_conv = 0;
      end else if (m_finish) begin
        e_busy = 1; e_done = 1; e_conv = m_conv; m_active = 0;
      end else begin
        i = (m_t - 1) / IT_LEN;
        p = (m_t - 1) % IT_LEN;
        e_busy = 1;
        if (m_t == 1) e_conv = 0;
        if (p < L1_LEN) begin
          e_en = 1; e_addr = 4'(p); e_clr = (p == 0);
        end else if (p < L1_LEN + LAT) begin
          e_c1 = (p == L1_LEN + LAT - 1);
        end else if (p < L1_LEN + LAT + L2_LEN) begin
          e_layer = 1; e_en = 1; e_addr = 4'(p - L1_LEN - LAT); e_clr = (e_addr == 0);
        end else if (p < IT_LEN - 1) begin
          e_layer = 1; e_c2 = (p == IT_LEN - 2);
        end else if (bus.err_ok) begin
          m_finish = 1; m_conv = 1;
        end else if (i == MAX_ITER - 1) begin
          m_finish = 1; m_conv = 0;
        end
      end
    end
  end

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst)
      check("cycle_outputs", dut_vec(),
            {e_addr, e_layer, e_en, e_clr, e_c1, e_c2, e_iter, e_busy, e_done, e_conv});
  end

  // ---------------- directed scenarios ----------------
  int          en_cnt, clr_cnt, l1c_k, l2c_k, done_k, done_iter, done_conv;
  logic [63:0] en_mask, clr_mask, layer_mask, busy_mask;
  logic [11:0] addr_seq;

  // Starts a solve and observes windows 1..limit (window k = after edge k).
  task automatic run(input int limit, input int abort_k, input int ok_iter, input int restart_k);
    en_cnt = 0; clr_cnt = 0; l1c_k = -1; l2c_k = -1; done_k = -1;
    done_iter = -1; done_conv = -1;
    en_mask = '0; clr_mask = '0; layer_mask = '0; busy_mask = '0; addr_seq = '0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (bus.acc_en)  en_cnt++;
      if (bus.acc_clr) clr_cnt++;
      if (k < 64) begin
        en_mask[k] = bus.acc_en; clr_mask[k] = bus.acc_clr;
        layer_mask[k] = bus.layer_sel; busy_mask[k] = bus.busy;
      end
      if (k <= 3) addr_seq[(k-1)*4 +: 4] = bus.in_addr;
      if (bus.l1_capture && l1c_k < 0) l1c_k = k;
      if (bus.l2_capture && l2c_k < 0) l2c_k = k;
      if (bus.done && done_k < 0) begin
        done_k = k; done_iter = int'(bus.iter_cnt); done_conv = int'(bus.converged);
      end
      bus.abort = (k == abort_k);
      bus.start = (k == restart_k);
      if (ok_iter >= 0 && int'(bus.iter_cnt) == ok_iter) bus.err_ok = 1'b1;
      if (done_k >= 0 && k >= done_k + 2) break;
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.err_ok = 1'b0;
    // 1. Reset, then five idle cycles.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en_cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.acc_en) en_cnt++;
    end
    check("s1_idle_outputs", dut_vec(), 0);
    check("s1_idle_acc_en", en_cnt, 0);

    // 2. Converges in the first iteration.
    bus.err_ok = 1'b1;
    run(40, -1, -1, -1);
    check("s2_acc_en_mask", en_mask[16:0], 17'h00F0E);
    check("s2_acc_clr_mask", clr_mask[16:0], 17'h00102);
    check("s2_layer_mask", layer_mask[16:0], 17'h0FF00);
    check("s2_addr_seq", addr_seq, 12'h210);
    check("s2_busy_c1", busy_mask[1], 1);
    check("s2_l1_capture", l1c_k, 7);
    check("s2_l2_capture", l2c_k, 15);
    check("s2_done_cycle", done_k, 17);
    check("s2_done_conv", done_conv, 1);
    check("s2_done_iter", done_iter, 0);

    // 3. Never converges: runs to the iteration limit.
    bus.err_ok = 1'b0;
    run(300, -1, -1, -1);
    check("s3_done_cycle", done_k, 257);
    check("s3_done_conv", done_conv, 0);
    check("s3_done_iter", done_iter, 15);
    check("s3_clr_count", clr_cnt, 32);

    // 4. Error flag rises during the third iteration.
    bus.err_ok = 1'b0;
    run(80, -1, 2, -1);
    check("s4_done_cycle", done_k, 49);
    check("s4_done_conv", done_conv, 1);
    check("s4_done_iter", done_iter, 2);

    // 5. Abort on cycle 10, then a clean restart.
    bus.err_ok = 1'b1;
    run(30, 10, -1, -1);
    check("s5_busy_c10", busy_mask[10], 1);
    check("s5_busy_c11", busy_mask[11], 0);
    check("s5_no_l2_capture", l2c_k, -1);
    check("s5_no_done", done_k, -1);
    check("s5_l1_capture", l1c_k, 7);
    run(40, -1, -1, -1);
    check("s5_restart_done", done_k, 17);
    check("s5_restart_iter", done_iter, 0);

    // 6. START while busy is ignored; reset mid-run clears everything.
    run(40, -1, -1, 5);
    check("s6_restart_ignored_done", done_k, 17);
    check("s6_restart_ignored_conv", done_conv, 1);
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("s6_async_reset_outputs", dut_vec(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("s6_idle_after_reset", dut_vec(), 0);
    run(40, -1, -1, -1);
    check("s6_post_reset_done", done_k, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
